// File: rtl/uram_req_port.sv
// uram_req_port: turns a valid/ready read/write request stream into single-port read-first UltraRAM
//   signals and returns read data as an ordered valid/ready response stream.
// Latency: RAM drive is combinational; a read fired in cycle T shows rsp_valid in cycle
//   T+RD_LATENCY+1 when the response FIFO is empty.
// Backpressure: at most RSP_DEPTH responses may be outstanding (in flight + buffered). req_ready drops
//   when credits run out, so capture never stalls. A pop frees its credit one cycle later.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   req_valid/req_ready             request handshake; req_we=1 write, 0 read
//   req_addr, req_wdata             request address and write data
//   ram_wr_en, ram_addr, ram_din    RAM port drive (pass-through of the request)
//   ram_dout                        RAM registered read data, RD_LATENCY cycles after the address edge
//   rsp_valid/rsp_ready, rsp_data   ordered response stream
//   rsp_wr                          write-ack flag (only with URAM_REQ_PORT_WR_ACK_EN)
//
// Optional feature macro: URAM_REQ_PORT_WR_ACK_EN
//   When defined, accepted writes take a credit and return a response with rsp_wr=1 and rsp_data=0,
//   ordered with the reads. When undefined, writes are fire-and-forget and rsp_wr does not exist.

module uram_req_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int RD_LATENCY = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
`ifdef URAM_REQ_PORT_WR_ACK_EN
  output logic                  rsp_wr,
`endif
  output logic [DATA_WIDTH-1:0] rsp_data
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

  logic                  w_fire;
  logic                  w_expect;
  logic                  w_push;
  logic                  w_pop;
  logic [CW-1:0]         w_outstanding;
  logic [DATA_WIDTH-1:0] w_push_data;

  // One bit per in-flight request that will produce a response; bit RD_LATENCY-1 lines up
  // with valid ram_dout for that request.
  logic [RD_LATENCY-1:0] r_inflight;
  logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  assign w_fire    = req_valid & req_ready;
  assign ram_addr  = req_addr;
  assign ram_din   = req_wdata;
  assign ram_wr_en = w_fire & req_we;

`ifdef URAM_REQ_PORT_WR_ACK_EN
  // Parallel tag tracking which in-flight/buffered entries are write acks.
  logic [RD_LATENCY-1:0] r_inflight_wr;
  logic [RSP_DEPTH-1:0]  r_mem_wr;

  assign w_expect    = w_fire;
  assign w_push_data = r_inflight_wr[RD_LATENCY-1] ? '0 : ram_dout;
  assign rsp_wr      = r_mem_wr[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight_wr <= '0;
      r_mem_wr      <= '0;
    end else begin
      r_inflight_wr[0] <= w_fire & req_we;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_inflight_wr[i] <= r_inflight_wr[i-1];
      end
      if (w_push) begin
        r_mem_wr[r_wr_ptr] <= r_inflight_wr[RD_LATENCY-1];
      end
    end
  end
`else
  assign w_expect    = w_fire & ~req_we;
  assign w_push_data = ram_dout;
`endif

  // Credits in use: responses still in the RAM pipeline plus those already buffered.
  always_comb begin
    w_outstanding = r_count;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_outstanding = w_outstanding + CW'(r_inflight[i]);
    end
  end

  // Only registered state feeds req_ready, so a pop this cycle frees its credit next cycle.
  assign req_ready = ~rst & (w_outstanding < DEPTH_C);

  assign w_push    = r_inflight[RD_LATENCY-1];
  assign rsp_valid = (r_count != '0);
  assign w_pop     = rsp_valid & rsp_ready;
  assign rsp_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_inflight[0] <= w_expect;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_inflight[i] <= r_inflight[i-1];
      end
      // Capture is unconditional: the credit check guarantees room.
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A push onto a full FIFO without a same-edge pop would mean the credit logic is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_count == DEPTH_C)));

endmodule

// File: tb/tb_uram_req_port.sv
module tb_uram_req_port;
  localparam int DW     = 32;
  localparam int AW     = 14;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 4;

  typedef logic [DW:0] rsp_t;  // {write-ack flag, data}

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_wr_s;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  rsp_t          exp_q[$];
  rsp_t          got_q[$];
  logic [DW-1:0] model_mem [0:(1<<AW)-1];

  // Behavioural single-port read-first RAM with RD_LAT registered output stages.
  logic [DW-1:0] ram_mem  [0:(1<<AW)-1];
  logic [DW-1:0] ram_pipe [RD_LAT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    ram_pipe[0] <= ram_mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    if (ram_wr_en) ram_mem[ram_addr] <= ram_din;
  end
  assign ram_dout = ram_pipe[RD_LAT-1];

`ifdef URAM_REQ_PORT_WR_ACK_EN
  logic rsp_wr;
  assign rsp_wr_s = rsp_wr;
`else
  assign rsp_wr_s = 1'b0;
`endif

  uram_req_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RD_LAT), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
`ifdef URAM_REQ_PORT_WR_ACK_EN
    .rsp_wr(rsp_wr),
`endif
    .rsp_data(rsp_data)
  );

  // Reference model: memory semantics plus strict request-order responses. Reset drops everything
  // not yet delivered.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      got_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) got_q.push_back({rsp_wr_s, rsp_data});
      if (req_valid && req_ready) begin
        if (req_we) begin
          model_mem[req_addr] = req_wdata;
`ifdef URAM_REQ_PORT_WR_ACK_EN
          exp_q.push_back({1'b1, {DW{1'b0}}});
`endif
        end else begin
          exp_q.push_back({1'b0, model_mem[req_addr]});
        end
      end
    end
  end

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int fc, output int waits);
    bit done = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    waits = 0; fc = -1;
    while (!done) begin
      @(negedge clk);
      if (req_ready) begin
        fc = cyc; done = 1;
      end else begin
        waits++;
        if (waits > 200) begin
          tests++; failed++;
          $display("FAIL send_timeout: req_ready=0 for %0d cycles, required 1", waits);
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int  n = 0;
    bit  done = 0;
    req_valid = 1'b0; rsp_ready = 1'b1;
    while (!done) begin
      @(negedge clk); #1;
      if (!rsp_valid && got_q.size() == exp_q.size()) done = 1;
      else begin
        n++;
        if (n > 200) begin
          tests++; failed++;
          $display("FAIL drain_timeout: got %0d responses, required %0d", got_q.size(), exp_q.size());
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    #1 rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (req_ready !== 1'b0) begin failed++; $display("FAIL rst_req_ready: got %b, required 0", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin failed++; $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid); end
    tests++; if (rsp_data !== '0) begin failed++; $display("FAIL rst_rsp_data: got %h, required 0", rsp_data); end
    tests++; if (ram_wr_en !== 1'b0) begin failed++; $display("FAIL rst_ram_wr_en: got %b, required 0", ram_wr_en); end
    #2 rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0;
    @(posedge clk); #1;
    tests++; if (req_ready !== 1'b1) begin failed++; $display("FAIL rst_release_ready: got %b, required 1", req_ready); end
  endtask

  task automatic test_basic();
    int fc, w, lat;
    bit seen = 0;
    rsp_ready = 1'b1;
    send(1'b1, 14'h005, 32'hDEADBEEF, fc, w);
    drain();
    got_q.delete(); exp_q.delete();
    send(1'b0, 14'h005, '0, fc, w);
    lat = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1; lat = cyc - fc; end
    end
    tests++; if (lat != RD_LAT + 1) begin failed++; $display("FAIL basic_latency: got %0d cycles, required %0d", lat, RD_LAT + 1); end
    drain();
    tests++; if (got_q.size() != 1) begin failed++; $display("FAIL basic_count: got %0d, required 1", got_q.size()); end
    else begin
      tests++; if (got_q[0] !== {1'b0, 32'hDEADBEEF}) begin failed++; $display("FAIL basic_data: got %h, required 0DEADBEEF", got_q[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int fc, w, total_waits = 0, base;
    drain();
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) begin send(1'b1, AW'(i), DW'(i * 3), fc, w); total_waits += w; end
    for (int i = 0; i < 8; i++) begin send(1'b0, AW'(i), '0, fc, w); total_waits += w; end
    tests++; if (total_waits != 0) begin failed++; $display("FAIL b2b_ready: got %0d stall cycles, required 0", total_waits); end
    drain();
    tests++; if (got_q.size() != exp_q.size()) begin failed++; $display("FAIL b2b_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    base = got_q.size() - 8;
    for (int i = 0; i < 8 && base >= 0; i++) begin
      tests++;
      if (got_q[base+i] !== {1'b0, DW'(i * 3)}) begin failed++; $display("FAIL b2b_data[%0d]: got %h, required %h", i, got_q[base+i], i * 3); end
    end
  endtask

  task automatic test_backpressure();
    int  acc = 0;
    bit  f;
    drain();
    got_q.delete(); exp_q.delete();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); f = req_valid && req_ready;
      @(posedge clk); #1;
      if (f) begin acc++; if (acc == 6) req_valid = 1'b0; else req_addr = AW'(acc); end
    end
    tests++; if (acc != DEPTH) begin failed++; $display("FAIL bp_accepted: got %0d, required %0d", acc, DEPTH); end
    @(negedge clk);
    tests++; if (req_ready !== 1'b0) begin failed++; $display("FAIL bp_ready_low: got %b, required 0", req_ready); end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && acc < 6; c++) begin
      @(negedge clk); f = req_valid && req_ready;
      @(posedge clk); #1;
      if (f) begin acc++; if (acc == 6) req_valid = 1'b0; else req_addr = AW'(acc); end
    end
    tests++; if (acc != 6) begin failed++; $display("FAIL bp_all_accepted: got %0d, required 6", acc); end
    drain();
    tests++; if (got_q.size() != 6) begin failed++; $display("FAIL bp_count: got %0d, required 6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== {1'b0, DW'(i * 3)}) begin failed++; $display("FAIL bp_data[%0d]: got %h, required %h", i, got_q[i], i * 3); end
    end
  endtask

  task automatic test_pop_push();
    int  acc = 0;
    bit  f;
    drain();
    got_q.delete(); exp_q.delete();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = AW'($urandom_range(0, 7));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); f = req_valid && req_ready;
      @(posedge clk); #1;
      if (f) begin acc++; req_addr = AW'($urandom_range(0, 7)); end
    end
    tests++; if (acc != DEPTH) begin failed++; $display("FAIL pp_fill: got %0d accepted, required %0d", acc, DEPTH); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      tests++;
      if (!rsp_valid || exp_q.size() == 0 || {rsp_wr_s, rsp_data} !== exp_q[0]) begin
        failed++; $display("FAIL pp_hold: got valid=%b data=%h, required valid=1 data=%h", rsp_valid, rsp_data, (exp_q.size() > 0) ? exp_q[0] : rsp_t'(0));
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); f = req_valid && req_ready;
      @(posedge clk); #1;
      if (f) begin acc++; req_addr = AW'($urandom_range(0, 7)); end
    end
    tests++; if (acc != 1) begin failed++; $display("FAIL pp_refill: got %0d accepted after one pop, required 1", acc); end
    tests++; if (rsp_valid !== 1'b1) begin failed++; $display("FAIL pp_valid: got %b, required 1", rsp_valid); end
    drain();
    tests++; if (got_q.size() != DEPTH + 1) begin failed++; $display("FAIL pp_count: got %0d, required %0d", got_q.size(), DEPTH + 1); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin failed++; $display("FAIL pp_data[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_flight();
    int fc, w, stale = 0;
    drain();
    send(1'b1, 14'h020, 32'h12345678, fc, w);
    drain();
    got_q.delete(); exp_q.delete();
    rsp_ready = 1'b1;
    send(1'b0, 14'h020, '0, fc, w);
    send(1'b0, 14'h020, '0, fc, w);
    #1 rst = 1'b1;
    #1;
    tests++; if (rsp_valid !== 1'b0) begin failed++; $display("FAIL rmf_valid: got %b, required 0", rsp_valid); end
    tests++; if (req_ready !== 1'b0) begin failed++; $display("FAIL rmf_ready: got %b, required 0", req_ready); end
    @(negedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (req_ready !== 1'b1) begin failed++; $display("FAIL rmf_ready_after: got %b, required 1", req_ready); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    #1;
    tests++; if (stale != 0 || got_q.size() != 0) begin failed++; $display("FAIL rmf_stale: got %0d valid cycles and %0d responses, required 0", stale, got_q.size()); end
    @(posedge clk); #1;
    send(1'b0, 14'h020, '0, fc, w);
    drain();
    tests++;
    if (got_q.size() != 1 || got_q[0] !== {1'b0, 32'h12345678}) begin
      failed++; $display("FAIL rmf_reread: got %0d responses first=%h, required 1 x 12345678", got_q.size(), (got_q.size() > 0) ? got_q[0] : rsp_t'(0));
    end
  endtask

  task automatic test_random();
    int fc, w;
    bit exp_wr;
    drain();
    for (int a = 0; a < 16; a++) send(1'b1, AW'(a), $urandom, fc, w);
    drain();
    got_q.delete(); exp_q.delete();
    for (int c = 0; c < 300; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom_range(0, 15));
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_wr = req_valid && req_ready && req_we;
      tests++;
      if (ram_wr_en !== exp_wr || ram_addr !== req_addr || ram_din !== req_wdata) begin
        failed++; $display("FAIL rnd_ram_drive: got wr_en=%b addr=%h din=%h, required %b %h %h", ram_wr_en, ram_addr, ram_din, exp_wr, req_addr, req_wdata);
      end
      @(posedge clk); #1;
    end
    drain();
    tests++; if (got_q.size() != exp_q.size()) begin failed++; $display("FAIL rnd_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin failed++; $display("FAIL rnd_data[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

`ifdef URAM_REQ_PORT_WR_ACK_EN
  task automatic test_wr_ack();
    int fc, w;
    drain();
    got_q.delete(); exp_q.delete();
    send(1'b1, 14'h010, 32'hCAFEF00D, fc, w);
    send(1'b0, 14'h010, '0, fc, w);
    drain();
    tests++; if (got_q.size() != 2) begin failed++; $display("FAIL ack_count: got %0d, required 2", got_q.size()); end
    else begin
      tests++; if (got_q[0] !== {1'b1, 32'h0}) begin failed++; $display("FAIL ack_write: got %h, required 100000000", got_q[0]); end
      tests++; if (got_q[1] !== {1'b0, 32'hCAFEF00D}) begin failed++; $display("FAIL ack_read: got %h, required 0CAFEF00D", got_q[1]); end
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_pop_push();
    test_reset_mid_flight();
    test_random();
`ifdef URAM_REQ_PORT_WR_ACK_EN
    test_wr_ack();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
